// File: rtl/testimage_pkg.sv
// Shared types and geometry for the test-image AXI4-Stream output stage.
package testimage_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FSYNC,
        STREAM,
        DONE
    } tim_state_t;

    localparam int TIM_H_ACTIVE = 640;
    localparam int TIM_V_ACTIVE = 480;
    localparam int TIM_PIX_W    = 24;

    // Counter width that stays legal for a 1-pixel dimension.
    function automatic int tim_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/testimage_axis_slice.sv
// Single-entry AXI4-Stream output register: loads only when free,
// holds payload and valid until the sink accepts it.
module testimage_axis_slice #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic         free
);

    assign free = !valid || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/testimage_axis_out.sv
// Pops pixel words from the generator FIFO and emits one AXI4-Stream
// video frame (tuser = SOF, tlast = EOL) per test_start, with fsync.
module testimage_axis_out
    import testimage_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH = TIM_PIX_W,
    parameter int H_ACTIVE            = TIM_H_ACTIVE,
    parameter int V_ACTIVE            = TIM_V_ACTIVE
) (
    input  logic                               m_axis_aclk,
    input  logic                               m_axis_aresetn,
    input  logic                               test_start,
    input  logic                               test_on,
    input  logic [31:0]                        fifo_rdata,
    input  logic                               fifo_empty,
    output logic                               fifo_rd,
    output logic                               s2mm_fsync,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic                               m_axis_tlast,
    output logic                               m_axis_tuser,
    output logic                               frame_busy,
    output logic                               frame_done,
    output logic [15:0]                        underrun_cnt
);

    localparam int XW = tim_cnt_w(H_ACTIVE);
    localparam int YW = tim_cnt_w(V_ACTIVE);
    localparam int PW = C_M_AXIS_DATA_WIDTH + 2;

    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    tim_state_t state, state_nxt;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          last_loaded;
    logic          slot_free;
    logic          can_pop;
    logic          starve;
    logic          handshake;
    logic [PW-1:0] slot_din;
    logic [PW-1:0] slot_dout;
    logic          unused_hi;

    assign unused_hi = &{1'b0, fifo_rdata[31:C_M_AXIS_DATA_WIDTH]};

    assign can_pop   = (state == STREAM) && slot_free
                       && test_on && !last_loaded;
    assign fifo_rd   = can_pop && !fifo_empty;
    assign starve    = can_pop && fifo_empty;
    assign handshake = m_axis_tvalid && m_axis_tready;

    assign s2mm_fsync   = (state == FSYNC);
    assign frame_done   = (state == DONE);
    assign frame_busy   = (state != IDLE);
    assign m_axis_tstrb = '1;

    assign slot_din = {(x == '0) && (y == '0),
                       (x == X_LAST),
                       fifo_rdata[C_M_AXIS_DATA_WIDTH-1:0]};

    testimage_axis_slice #(
        .W (PW)
    ) u_slice (
        .clk   (m_axis_aclk),
        .rst_n (m_axis_aresetn),
        .load  (fifo_rd),
        .din   (slot_din),
        .ready (m_axis_tready),
        .valid (m_axis_tvalid),
        .dout  (slot_dout),
        .free  (slot_free)
    );

    assign m_axis_tuser = slot_dout[PW-1];
    assign m_axis_tlast = slot_dout[PW-2];
    assign m_axis_tdata = slot_dout[C_M_AXIS_DATA_WIDTH-1:0];

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An aborted frame leaves STREAM only once the held beat has drained.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (test_start && test_on) state_nxt = FSYNC;
            end
            FSYNC: begin
                state_nxt = test_on ? STREAM : IDLE;
            end
            STREAM: begin
                if (last_loaded && handshake) state_nxt = DONE;
                else if (!test_on && slot_free) state_nxt = IDLE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Raster position advances on slot load, not on the sink handshake.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            x            <= '0;
            y            <= '0;
            last_loaded  <= 1'b0;
            underrun_cnt <= '0;
        end else if (state == FSYNC) begin
            x            <= '0;
            y            <= '0;
            last_loaded  <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            if (fifo_rd) begin
                if (x == X_LAST) begin
                    x <= '0;
                    if (y == Y_LAST) last_loaded <= 1'b1;
                    else y <= y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
            if (starve && underrun_cnt != 16'hFFFF) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
        end
    end

endmodule
